// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
// The release pulse is named rel because release is a reserved word.
interface rr_grant_arbiter_if #(
   parameter int NREQ = 8
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic                enable;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     rel;
   logic [NREQ-1:0]     grant;
   logic [IDXW-1:0]     grant_idx;
   logic                grant_v;
   logic                timeout;

   modport master (
      output enable, req, rel,
      input  grant, grant_idx, grant_v, timeout
   );

   modport slave (
      input  enable, req, rel,
      output grant, grant_idx, grant_v, timeout
   );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: registered one-hot grant one edge after a request; held until release, request drop or MAX_HOLD timeout.
// Backpressure: a single owner at a time; other requesters wait, and enable low only blocks new grants.
module rr_grant_arbiter #(
   parameter int NREQ     = 8,
   parameter int MAX_HOLD = 64
) (
   input logic              clk,
   input logic              rst,
   rr_grant_arbiter_if.slave bus
);
   localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CNTW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [IDXW-1:0] LAST_INIT = IDXW'(NREQ - 1);
   localparam logic [CNTW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNTW'(MAX_HOLD - 1) : '0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state, state_nx;
   logic [NREQ-1:0] grant_q, grant_nx;
   logic [IDXW-1:0] idx_q, idx_nx;
   logic            vld_q, vld_nx;
   logic            tmo_q, tmo_nx;
   logic [IDXW-1:0] last_idx, last_nx;
   logic [CNTW-1:0] hold_cnt, cnt_nx;

   logic            win_found;
   logic [IDXW-1:0] win_idx;

   // Scan upward from the slot after the previous winner, wrapping once.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!win_found && bus.req[IDXW'((int'(last_idx) + k) % NREQ)]) begin
            win_found = 1'b1;
            win_idx   = IDXW'((int'(last_idx) + k) % NREQ);
         end
      end
   end

   always_comb begin
      state_nx = state;
      grant_nx = grant_q;
      idx_nx   = idx_q;
      vld_nx   = vld_q;
      tmo_nx   = 1'b0;
      last_nx  = last_idx;
      cnt_nx   = hold_cnt;
      case (state)
         IDLE: begin
            if (bus.enable && win_found) begin
               state_nx = BUSY;
               grant_nx = NREQ'(1) << win_idx;
               idx_nx   = win_idx;
               vld_nx   = 1'b1;
               last_nx  = win_idx;
               cnt_nx   = '0;
            end
         end
         BUSY: begin
            cnt_nx = (hold_cnt == '1) ? hold_cnt : hold_cnt + CNTW'(1);
            // Owner release or request drop takes precedence over the timeout.
            if (bus.rel[idx_q] || !bus.req[idx_q]) begin
               state_nx = IDLE;
               grant_nx = '0;
               idx_nx   = '0;
               vld_nx   = 1'b0;
            end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
               state_nx = IDLE;
               grant_nx = '0;
               idx_nx   = '0;
               vld_nx   = 1'b0;
               tmo_nx   = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         grant_q  <= '0;
         idx_q    <= '0;
         vld_q    <= 1'b0;
         tmo_q    <= 1'b0;
         last_idx <= LAST_INIT;
         hold_cnt <= '0;
      end else begin
         state    <= state_nx;
         grant_q  <= grant_nx;
         idx_q    <= idx_nx;
         vld_q    <= vld_nx;
         tmo_q    <= tmo_nx;
         last_idx <= last_nx;
         hold_cnt <= cnt_nx;
      end
   end

   assign bus.grant     = grant_q;
   assign bus.grant_idx = idx_q;
   assign bus.grant_v   = vld_q;
   assign bus.timeout   = tmo_q;
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed scenarios plus a randomized phase, each cycle compared against a behavioural ownership model.
module tb_rr_grant_arbiter;
   localparam int N  = 8;
   localparam int MH = 4;

   logic clk;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   // Reference model: current owner (-1 when idle), last winner, cycles owned so far.
   int   m_owner;
   int   m_last;
   int   m_held;
   bit   m_tmo;

   rr_grant_arbiter_if #(.NREQ(N)) bus ();

   rr_grant_arbiter #(.NREQ(N), .MAX_HOLD(MH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_last  = N - 1;
      m_held  = 0;
      m_tmo   = 1'b0;
   endtask

   task automatic model_step();
      m_tmo = 1'b0;
      if (!rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         if (bus.enable && bus.req != '0) begin
            for (int k = 1; k <= N; k++) begin
               int c;
               c = (m_last + k) % N;
               if (m_owner < 0 && bus.req[c]) m_owner = c;
            end
            m_last = m_owner;
            m_held = 1;
         end
      end else if (bus.rel[m_owner] || !bus.req[m_owner]) begin
         m_owner = -1;
      end else if (m_held == MH) begin
         m_owner = -1;
         m_tmo   = 1'b1;
      end else begin
         m_held++;
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
      check({tag, "_grant"}, 32'(bus.grant), 32'(eg));
      check({tag, "_idx"},   32'(bus.grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      check({tag, "_v"},     32'(bus.grant_v), 32'(m_owner >= 0));
      check({tag, "_tmo"},   32'(bus.timeout), 32'(m_tmo));
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_model(tag);
   endtask

   // Called at edge+1; reset pulse stays between clock edges.
   task automatic do_reset();
      rst = 1'b0;
      #1;
      model_reset();
      check("rst_grant", 32'(bus.grant), 32'd0);
      check("rst_v", 32'(bus.grant_v), 32'd0);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      int order [5] = '{0, 2, 7, 0, 2};

      rst        = 1'b1;
      bus.enable = 1'b1;
      bus.req    = 8'hFF;
      bus.rel    = '0;
      model_reset();

      // Reset with all requests active.
      #2 rst = 1'b0;
      #1;
      check("reset_grant", 32'(bus.grant), 32'd0);
      check("reset_idx", 32'(bus.grant_idx), 32'd0);
      check("reset_v", 32'(bus.grant_v), 32'd0);
      check("reset_tmo", 32'(bus.timeout), 32'd0);
      tick("in_reset");
      rst = 1'b1;
      tick("first_grant");
      check("first_grant_onehot", 32'(bus.grant), 32'h01);

      // Rotation with an idle cycle between grants.
      do_reset();
      bus.req = 8'b1000_0101;
      for (int k = 0; k < 5; k++) begin
         tick("rot_grant");
         check("rot_order", 32'(bus.grant_idx), 32'(order[k]));
         bus.rel = N'(1) << order[k];
         tick("rot_release");
         check("rot_dead", 32'(bus.grant_v), 32'd0);
         bus.rel = '0;
      end

      // Owner drops its request.
      do_reset();
      bus.req = 8'h10;
      tick("drop_grant");
      check("drop_idx", 32'(bus.grant_idx), 32'd4);
      bus.req = '0;
      tick("drop_rel");
      check("drop_v", 32'(bus.grant_v), 32'd0);
      check("drop_tmo", 32'(bus.timeout), 32'd0);

      // Hold-limit timeout.
      do_reset();
      bus.req = 8'h02;
      tick("to_grant");
      for (int k = 0; k < 3; k++) begin
         tick("to_hold");
         check("to_held_v", 32'(bus.grant_v), 32'd1);
      end
      tick("to_fire");
      check("to_pulse", 32'(bus.timeout), 32'd1);
      check("to_v_low", 32'(bus.grant_v), 32'd0);
      tick("to_regrant");
      check("to_regrant_idx", 32'(bus.grant_idx), 32'd1);
      check("to_pulse_end", 32'(bus.timeout), 32'd0);

      // Enable gating.
      do_reset();
      bus.enable = 1'b0;
      bus.req    = 8'h0C;
      tick("en_off");
      tick("en_off2");
      check("en_off_v", 32'(bus.grant_v), 32'd0);
      bus.enable = 1'b1;
      tick("en_on");
      check("en_on_idx", 32'(bus.grant_idx), 32'd2);
      bus.enable = 1'b0;
      tick("en_drop");
      check("en_persist", 32'(bus.grant_v), 32'd1);
      bus.rel = 8'h04;
      tick("en_release");
      check("en_released", 32'(bus.grant_v), 32'd0);
      bus.rel    = '0;
      bus.enable = 1'b1;

      // Asynchronous reset while index 5 owns the resource.
      do_reset();
      bus.req = 8'h20;
      tick("mid_grant");
      check("mid_idx", 32'(bus.grant_idx), 32'd5);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check("mid_rst_grant", 32'(bus.grant), 32'd0);
      check("mid_rst_v", 32'(bus.grant_v), 32'd0);
      check("mid_rst_idx", 32'(bus.grant_idx), 32'd0);
      bus.req = 8'h21;
      #1 rst = 1'b1;
      tick("mid_after");
      check("mid_after_idx", 32'(bus.grant_idx), 32'd0);

      // Randomized traffic against the model.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 3) == 0) bus.req = N'($urandom);
         bus.enable = ($urandom_range(0, 4) != 0);
         bus.rel    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         tick("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Round-robin arbiter that shares a single downstream resource among `NREQ` requesters. Each cycle in which the resource is free, it selects one active request by rotating priority, issues a registered one-hot grant plus its binary index, and holds the grant until the owner releases it or a hold-limit timeout forces release. It is the sequencing layer in front of the priority-encoded request datapath. It turns a static lowest-index-wins selection into fair, handshaked ownership.

## Interface

**Parameters**
- `NREQ`, default 8: number of requesters; legal range is ≥ 2.
- `MAX_HOLD`, default 64: maximum number of cycles a grant may be held; 0 disables the timeout.

**Ports**
- `clk`, in, 1: sole clock; all logic is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: when low, no new grant is issued; an existing grant is unaffected.
- `req`, in, `NREQ`: per-requester request level.
- `release`, in, `NREQ`: per-requester release pulse; only the bit of the current owner is honoured.
- `grant`, out reg, `NREQ`: one-hot grant; all zeros when idle.
- `grant_idx`, out reg, `$clog2(NREQ)`: binary index of the owner; 0 when idle.
- `grant_v`, out reg, 1: resource is currently owned.
- `timeout`, out reg, 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- **Reset values:** `grant`=0, `grant_idx`=0, `grant_v`=0, `timeout`=0, state=IDLE, `last_idx`=`NREQ`-1, hold counter=0.
- **FSM states:** IDLE and BUSY.
- **IDLE:**
  - If `enable`=1 and `req`≠0, pick a winner and go to BUSY. Otherwise stay in IDLE.
- **Winner selection:**
  - Search starts at `(last_idx+1) mod NREQ` and scans upward with wrap-around.
  - The first set `req` bit wins.
  - With `last_idx`=`NREQ`-1 after reset, index 0 has top priority first.
- **On grant:**
  - `grant`=onehot(winner), `grant_idx`=winner, `grant_v`=1.
  - `last_idx`=winner.
  - Hold counter is cleared.
- **BUSY:**
  - Hold counter increments every cycle and saturates; its width is `$clog2(MAX_HOLD+1)`, minimum 1.
  - Release occurs when any of the following is true:
    - (a) `release[grant_idx]`=1.
    - (b) `req[grant_idx]`=0 (the owner dropped its request).
    - (c) `MAX_HOLD`≠0 and the counter equals `MAX_HOLD`-1 with neither (a) nor (b) true.
  - On release, go to IDLE and clear `grant`, `grant_idx` and `grant_v`.
  - Case (c) also pulses `timeout`=1 for one cycle.
  - `release` or `req` bits belonging to non-owners are ignored in BUSY.
- **Fairness:** after an owner finishes, every other active requester is served before that owner is served again.
- **Simultaneous events:**
  - (a)/(b) coinciding with the timeout cycle count as a normal release; `timeout` stays 0.
  - An `enable` transition during BUSY has no effect on the current grant.
- **Reset mid-grant:** all outputs drop immediately (asynchronous). After reset deasserts, priority restarts at index 0.
- **Invariants:**
  - `grant` is zero or one-hot.
  - `grant_v` = |`grant`.
  - `grant_idx` = encode(`grant`).

## Timing
- **Grant latency:** `req` sampled high in IDLE at edge N gives `grant_v`=1 after edge N.
- **Grant length:** a grant is held for at least 1 cycle.
- **Release latency:** a release observed at edge M gives `grant_v`=0 after edge M.
- **Dead cycle:** there is exactly one idle cycle between consecutive grants. Back-to-back streaming reaches at most 1 grant per 2 cycles plus the hold time.
- **Timeout:**
  - The maximum `grant_v` high time is `MAX_HOLD` cycles.
  - `timeout` is high in the same cycle in which `grant_v` first reads 0.
- **Output timing:** all outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- **Reset:** assert `rst`=0 with `req`=8'hFF → all outputs 0. Deassert, then after 1 edge → `grant`=8'h01, `grant_idx`=0.
- **Rotation:** hold `req`=8'b1000_0101 and pulse the owner's `release` on each grant → grant order is 0, 2, 7, 0, 2, with one idle cycle between each.
- **Request drop:** `req`=8'h10 granted, then `req` falls to 0 → `grant_v`=0 the next cycle and `timeout`=0.
- **Timeout:** with `MAX_HOLD`=4, `req`=8'h02 is held high and never released → `grant_v` is high for 4 cycles, then `timeout` pulses once. The next grant is index 1 again after the idle cycle, since it is the only requester.
- **Enable gating:** `enable`=0 with `req`=8'h0C → no grant. Raise `enable` → grant to index 2. Drop `enable` mid-grant → the grant persists until `release`.
- **Reset mid-grant:** owner index 5 is active when `rst` is pulsed low asynchronously between edges → outputs clear immediately. After reset with `req`=8'h21 → the grant goes to index 0.
